fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 170 +++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drain-side reader for the synchronous FIFO: pops a programmed burst and streams it out via valid/ready.
// Optional: define FIFO_READER_LAST_EN to add an m_last output that flags the final beat of each burst.
module fifo_stream_reader #(
    parameter int Datawidth = 8,
    parameter int LEN_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     burst_len,
    output logic                 busy,
    output logic                 done,
    output logic                 read,
    input  logic [Datawidth-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic [Datawidth-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
`ifdef FIFO_READER_LAST_EN
    ,
    output logic                 m_last
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [LEN_W-1:0]     remaining_q;
    logic                 inflight_q;
    logic [1:0]           buf_count_q;
    logic [Datawidth-1:0] head_q;
    logic [Datawidth-1:0] tail_q;
    logic                 pop;
    logic [2:0]           occupancy_next;
    logic                 last_read;

    assign m_valid = (buf_count_q != 2'd0);
    assign m_data  = head_q;
    assign pop     = m_valid && m_ready;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    // Entries the skid buffer will hold after this edge; a new read is safe only if one slot stays free.
    assign occupancy_next = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign read = !rst && (state_q == S_RUN) && !fifo_empty
                  && (remaining_q != '0) && (occupancy_next < 3'd2);

    assign last_read = read && (remaining_q == LEN_W'(1));

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (burst_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_read) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!inflight_q && (buf_count_q == 2'd0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= read;
            if ((state_q == S_IDLE) && start) begin
                remaining_q <= burst_len;
            end else if (read) begin
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

    // Two-entry skid buffer; head drives the stream, capture lands at the first free slot after any pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset too because m_data must read zero out of reset.
            buf_count_q <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            case ({inflight_q, pop})
                2'b10: begin
                    if (buf_count_q == 2'd0) begin
                        head_q <= fifo_data;
                    end else begin
                        tail_q <= fifo_data;
                    end
                    buf_count_q <= buf_count_q + 2'd1;
                end
                2'b01: begin
                    head_q      <= tail_q;
                    buf_count_q <= buf_count_q - 2'd1;
                end
                2'b11: begin
                    if (buf_count_q == 2'd1) begin
                        head_q <= fifo_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_READER_LAST_EN
    logic inflight_last_q;
    logic head_last_q;
    logic tail_last_q;

    assign m_last = m_valid && head_last_q;

    // Last-beat flag travels alongside each entry exactly like the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_last_q <= 1'b0;
            head_last_q     <= 1'b0;
            tail_last_q     <= 1'b0;
        end else begin
            inflight_last_q <= last_read;
            case ({inflight_q, pop})
                2'b10: begin
                    if (buf_count_q == 2'd0) begin
                        head_last_q <= inflight_last_q;
                    end else begin
                        tail_last_q <= inflight_last_q;
                    end
                end
                2'b01: head_last_q <= tail_last_q;
                2'b11: begin
                    if (buf_count_q == 2'd1) begin
                        head_last_q <= inflight_last_q;
                    end else begin
                        head_last_q <= tail_last_q;
                        tail_last_q <= inflight_last_q;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: queue-based FIFO model, expected-beat scoreboard, random bursts.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          read;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
`ifdef FIFO_READER_LAST_EN
    logic          m_last;
`endif

    fifo_stream_reader #(.Datawidth(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .read       (read),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef FIFO_READER_LAST_EN
        ,
        .m_last     (m_last)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] exp_q[$];

    int   cyc = 0;
    int   push_every = 0;
    int   ready_mode = 0;
    int   rcnt = 0;
    bit   hold_start = 1'b0;

    int   cur_len, beats, done_cnt, read_cnt, done_cyc;
    int   first_read, last_read, first_valid, last_valid;
    bit   stalled_prev;
    logic [DW-1:0] stall_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic sample();
        if (read) begin
            check("read_not_empty", fifo_empty, 0);
            read_cnt++;
            if (first_read < 0) first_read = cyc;
            last_read = cyc;
        end
        if (stalled_prev) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, stall_data);
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (m_valid && m_ready) begin
            check("beat_in_range", beats < cur_len, 1);
            if (exp_q.size() > 0) check("beat_data", m_data, exp_q.pop_front());
`ifdef FIFO_READER_LAST_EN
            check("m_last", m_last, beats == cur_len - 1);
`endif
            beats++;
            last_valid = cyc;
        end
        stalled_prev = m_valid && !m_ready;
        stall_data   = m_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // One clock: FIFO pops on the edge using the pre-edge read, inputs change 1ns later, outputs sampled on negedge.
    task automatic tick();
        @(posedge clk);
        if (read && fq.size() > 0) fifo_data <= fq.pop_front();
        cyc++;
        #1;
        if (!hold_start) start = 1'b0;
        if (push_every > 0 && pend.size() > 0 && (cyc % push_every) == 0) fq.push_back(pend.pop_front());
        fifo_empty = (fq.size() == 0);
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((rcnt % 3) == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        rcnt++;
        @(negedge clk);
        if (!rst) sample();
    endtask

    task automatic clear_stats(input int len);
        cur_len = len; beats = 0; done_cnt = 0; read_cnt = 0; done_cyc = -1;
        first_read = -1; last_read = -1; first_valid = -1; last_valid = -1;
        stalled_prev = 1'b0;
    endtask

    task automatic run_burst(input int len, input int preload, input int interval,
                             input int rmode, input bit extra_start, input bit chk_lat);
        int e0;
        int cnt;
        int budget;
        logic [DW-1:0] d;
        exp_q.delete();
        pend.delete();
        for (int i = 0; i < len; i++) begin
            d = DW'($urandom);
            if (chk_lat) d = DW'((i + 1) * 8'h11);
            exp_q.push_back(d);
            if (i < preload) fq.push_back(d);
            else pend.push_back(d);
        end
        fifo_empty = (fq.size() == 0);
        push_every = interval;
        ready_mode = rmode;
        rcnt       = 0;
        clear_stats(len);
        start     = 1'b1;
        burst_len = LW'(len);
        tick();
        e0 = cyc;
        check("busy_after_start", busy, 1);
        budget = 100 + len * 30;
        cnt    = 0;
        while (done_cnt == 0 && cnt < budget) begin
            if (extra_start && cnt == 3) begin
                start     = 1'b1;
                burst_len = LW'(2);
            end
            tick();
            cnt++;
        end
        check("done_seen", done_cnt, 1);
        if (extra_start) begin
            start     = 1'b1;
            burst_len = LW'(3);
        end
        tick();
        check("busy_after_done", busy, 0);
        tick();
        check("done_pulses", done_cnt, 1);
        check("beat_count", beats, len);
        check("exp_drained", exp_q.size(), 0);
        check("fifo_drained", fq.size(), 0);
        check("idle_no_valid", m_valid, 0);
        if (len == 0) begin
            check("len0_no_read", read_cnt, 0);
            check("len0_no_valid", first_valid, -1);
            check("len0_done_lat", done_cyc - e0, 0);
        end
        if (chk_lat) begin
            check("first_read_lat", first_read - e0, 0);
            check("read_count", read_cnt, len);
            check("read_consecutive", last_read - first_read, len - 1);
            check("first_valid_lat", first_valid - e0, 2);
            check("beats_consecutive", last_valid - first_valid, len - 1);
        end
    endtask

    task automatic reset_mid_burst();
        int cnt;
        exp_q.delete();
        pend.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(DW'($urandom));
            fq.push_back(exp_q[i]);
        end
        fifo_empty = 1'b0;
        push_every = 0;
        ready_mode = 0;
        clear_stats(6);
        start     = 1'b1;
        burst_len = LW'(6);
        cnt = 0;
        while (beats < 2 && cnt < 50) begin
            tick();
            cnt++;
        end
        check("pre_reset_beats", beats, 2);
        rst = 1'b1;
        tick();
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_read", read, 0);
        rst = 1'b0;
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        clear_stats(0);
        tick();
        tick();
        check("post_rst_idle", busy, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        hold_start = 1'b1;
        burst_len  = LW'(4);
        fifo_data  = '0;
        fifo_empty = 1'b1;
        m_ready    = 1'b1;
        clear_stats(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy_hold", busy, 0);
            check("rst_read_hold", read, 0);
            check("rst_valid_hold", m_valid, 0);
            check("rst_done_hold", done, 0);
            check("rst_data_hold", m_data, 0);
        end
        hold_start = 1'b0;
        start      = 1'b0;
        rst        = 1'b0;
        tick();

        run_burst(4, 4, 0, 0, 1'b0, 1'b1);
        run_burst(4, 4, 0, 1, 1'b0, 1'b0);
        run_burst(3, 0, 5, 0, 1'b0, 1'b0);
        run_burst(0, 0, 0, 0, 1'b0, 1'b0);
        run_burst(5, 5, 0, 2, 1'b1, 1'b0);
        reset_mid_burst();
        run_burst(6, 6, 0, 1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            int len;
            len = int'($urandom_range(1, 12));
            run_burst(len, int'($urandom_range(0, len)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
